control_sequencer: RTL and testbench

//  Hardwired Mini SRC control unit: the stage directly upstream of DataPath.

---
 rtl/control_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// control_sequencer: hardwired Mini SRC control unit, fetch T0-T2 then opcode execute T3-T7. Rev 1.0
// Optional MEM_WAIT_EN: memory steps stall on Mem_ready; WAIT_MAX stalled cycles -> HALT with sticky Err.
module control_sequencer #(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned WAIT_MAX        = 15
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        RAin,
  output logic        OutPortIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        NEG,
  output logic        NOT,
  output logic        Run,
  output logic        Err
);

  // Tn encodes as n so the low three bits give the step number directly.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RESET = 4'd8, S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011, OP_JR   = 5'b10100, OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] op;
  logic [2:0] step, last_step;
  logic       legal, stop_op, alu_en;

  assign op   = IR[31:27];
  assign step = state_q[2:0];

  always_comb begin
    legal     = 1'b1;
    last_step = 3'd3;
    case (op)
      OP_LD, OP_ST:                            last_step = 3'd7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:                last_step = 3'd5;
      OP_NEG, OP_NOT, OP_JAL:                  last_step = 3'd4;
      OP_BR:                                   last_step = 3'd6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
      OP_NOP, OP_HALT:                         last_step = 3'd3;
      default:                                 legal     = 1'b0;
    endcase
    stop_op = (op == OP_HALT) || (HALT_ON_ILLEGAL && !legal);
  end

`ifdef MEM_WAIT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d, mem_step;
  assign Err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{Mem_ready, WAIT_MAX[0]};
  assign Err        = 1'b0;
`endif
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_RESET;
`ifdef MEM_WAIT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_WAIT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, RAin, OutPortIn} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write} = '0;
    {ADD, SUB, AND, OR, NEG, NOT} = '0;
    alu_en = 1'b0;
    Run    = (state_q != S_RESET) && (state_q != S_HALT);

    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0, S_T1, S_T2: state_d = state_t'(state_q + 4'd1);
      default: begin
        if (stop_op)                state_d = S_HALT;
        else if (step == last_step) state_d = Stop ? S_HALT : S_T0;
        else                        state_d = state_t'(state_q + 4'd1);
      end
    endcase

    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_RESET, S_HALT: ;
      default: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              3'd3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              3'd4: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
              3'd5: begin
                Zlowout = 1'b1;
                if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else              MARin = 1'b1;
              end
              3'd6: begin
                MDRin = 1'b1;
                if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; end
                else             Read = 1'b1;
              end
              3'd7: begin
                if (op == OP_ST) Write = 1'b1;
                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              3'd3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd4: begin
                alu_en = 1'b1; Zin = 1'b1;
                if (op[3]) Cout = 1'b1;
                else begin Grc = 1'b1; Rout = 1'b1; end
              end
              3'd5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            if (step == 3'd3) begin Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
            else begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          OP_BR: begin
            // CON_FF is only consulted in the final step, after CONin has captured it.
            case (step)
              3'd3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              3'd4: begin PCout = 1'b1; Yin = 1'b1; end
              3'd5: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
              3'd6: begin Zlowout = 1'b1; PCin = CON_FF; end
              default: ;
            endcase
          end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL: begin
            if (step == 3'd3) begin PCout = 1'b1; RAin = 1'b1; Rin = 1'b1; end
            else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
    endcase

    if (alu_en) begin
      case (op)
        OP_ADD, OP_ADDI: ADD = 1'b1;
        OP_SUB:          SUB = 1'b1;
        OP_AND, OP_ANDI: AND = 1'b1;
        OP_OR, OP_ORI:   OR  = 1'b1;
        OP_NEG:          NEG = 1'b1;
        OP_NOT:          NOT = 1'b1;
        default: ;
      endcase
    end

`ifdef MEM_WAIT_EN
    // Counter is zero on entry to every access and counts stalled cycles within it.
    mem_step = (state_q == S_T1) || (op == OP_LD && state_q == S_T6) ||
               (op == OP_ST && state_q == S_T7);
    wait_d   = '0;
    err_d    = err_q;
    if (mem_step && !Mem_ready) begin
      if (wait_q == 8'(WAIT_MAX - 1)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        state_d = state_q;
        wait_d  = wait_q + 8'd1;
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: expected per-cycle control words are queued by the stimulus
// and popped/compared by an independent negedge monitor.
module tb_control_sequencer;
  typedef logic [35:0] cw_t;

  localparam cw_t B_PCOUT = 36'd1 << 0,  B_ZLOW = 36'd1 << 1,  B_MDROUT = 36'd1 << 3;
  localparam cw_t B_HIOUT = 36'd1 << 4,  B_COUT = 36'd1 << 7,  B_PCIN   = 36'd1 << 8;
  localparam cw_t B_IRIN  = 36'd1 << 9,  B_MARIN = 36'd1 << 10, B_MDRIN = 36'd1 << 11;
  localparam cw_t B_YIN   = 36'd1 << 12, B_ZIN  = 36'd1 << 13, B_CONIN  = 36'd1 << 16;
  localparam cw_t B_RAIN  = 36'd1 << 17, B_OUTP = 36'd1 << 18, B_GRA    = 36'd1 << 19;
  localparam cw_t B_GRB   = 36'd1 << 20, B_GRC  = 36'd1 << 21, B_RIN    = 36'd1 << 22;
  localparam cw_t B_ROUT  = 36'd1 << 23, B_BAOUT = 36'd1 << 24, B_INCPC = 36'd1 << 25;
  localparam cw_t B_READ  = 36'd1 << 26, B_WRITE = 36'd1 << 27, B_ADD   = 36'd1 << 28;
  localparam cw_t B_SUB   = 36'd1 << 29, B_AND  = 36'd1 << 30, B_NOT    = 36'd1 << 33;
  localparam cw_t B_RUN   = 36'd1 << 34, B_ERR  = 36'd1 << 35, ZERO     = 36'd0;
  localparam cw_t F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam cw_t F1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam cw_t F2 = B_MDROUT | B_IRIN | B_RUN;

  logic        Clock = 1'b0, Clear_n, CON_FF, Stop, Mem_ready;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, RAin, OutPortIn;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write;
  logic ADD, SUB, AND, OR, NEG, NOT, Run, Err;

  control_sequencer dut (
    .Clock(Clock), .Clear_n(Clear_n), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Mem_ready(Mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .RAin(RAin),
    .OutPortIn(OutPortIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .NEG(NEG), .NOT(NOT), .Run(Run), .Err(Err)
  );

  always #5 Clock = ~Clock;

  cw_t got;
  assign got = {Err, Run, NOT, NEG, OR, AND, SUB, ADD, Write, Read, IncPC, BAout, Rout, Rin,
                Grc, Grb, Gra, OutPortIn, RAin, CONin, LOin, HIin, Zin, Yin, MDRin, MARin,
                IRin, PCin, Cout, InPortout, LOout, HIout, MDRout, Zhighout, Zlowout, PCout};

  cw_t   sb[$];
  string tq[$];
  cw_t   exq[$];
  cw_t   mon_w;
  string mon_t;
  int    n_checks = 0;
  int    n_fail   = 0;

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      mon_w = sb.pop_front();
      mon_t = tq.pop_front();
      n_checks++;
      if (got !== mon_w) begin
        n_fail++;
        $display("FAIL %s: control word got %h, expected %h", mon_t, got, mon_w);
      end
    end
  end

  task automatic push(input cw_t w, input string t);
    sb.push_back(w);
    tq.push_back(t);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic add(input cw_t w);
    exq.push_back(w | B_RUN);
  endtask

  task automatic push_fetch(input string t);
    push(F0, {t, " T0"});
    push(F1, {t, " T1"});
    push(F2, {t, " T2"});
  endtask

  // Called at posedge+1 of a T0 cycle; returns at posedge+1 of the following T0.
  task automatic instr(input logic [31:0] ir, input logic con, input string t);
    IR     = ir;
    CON_FF = con;
    push_fetch(t);
    foreach (exq[i]) push(exq[i], $sformatf("%s T%0d", t, i + 3));
    cycles(3 + exq.size());
    exq.delete();
  endtask

  task automatic reset_pulse(input string t);
    Clear_n = 1'b0;
    push(ZERO, t);
    @(negedge Clock);
    #1;
    Clear_n = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0; Mem_ready = 1'b1; Clear_n = 1'b0;
    cycles(2);
    reset_pulse("reset state");

    add(B_GRB | B_BAOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN); add(B_ZLOW | B_GRA | B_RIN);
    instr(32'h0A000000, 1'b0, "ldi");

    add(B_GRA | B_ROUT | B_CONIN); add(B_PCOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN);
    add(B_ZLOW | B_PCIN);
    instr(32'h99800023, 1'b1, "br taken");
    add(B_GRA | B_ROUT | B_CONIN); add(B_PCOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN);
    add(B_ZLOW);
    instr(32'h99800023, 1'b0, "br not taken");

    add(B_GRB | B_BAOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN); add(B_ZLOW | B_MARIN);
    add(B_GRA | B_ROUT | B_MDRIN); add(B_WRITE);
    instr(32'h10000000, 1'b0, "st");

    add(B_GRB | B_BAOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN); add(B_ZLOW | B_MARIN);
    add(B_READ | B_MDRIN); add(B_MDROUT | B_GRA | B_RIN);
    instr(32'h00000000, 1'b0, "ld");

    add(B_GRB | B_ROUT | B_YIN); add(B_GRC | B_ROUT | B_SUB | B_ZIN); add(B_ZLOW | B_GRA | B_RIN);
    instr(32'h20000000, 1'b0, "sub");
    add(B_GRB | B_ROUT | B_YIN); add(B_COUT | B_AND | B_ZIN); add(B_ZLOW | B_GRA | B_RIN);
    instr(32'h68000000, 1'b0, "andi");
    add(B_GRB | B_ROUT | B_NOT | B_ZIN); add(B_ZLOW | B_GRA | B_RIN);
    instr(32'h90000000, 1'b0, "not");
    add(B_PCOUT | B_RAIN | B_RIN); add(B_GRA | B_ROUT | B_PCIN);
    instr(32'hA8000000, 1'b0, "jal");
    add(B_HIOUT | B_GRA | B_RIN);
    instr(32'hC0000000, 1'b0, "mfhi");
    add(B_GRA | B_ROUT | B_OUTP);
    instr(32'hB8000000, 1'b0, "out");

    // Stop raised during add T4: add finishes, then HALT persists until Clear_n.
    IR = 32'h18000000;
    push_fetch("add stop");
    push(B_GRB | B_ROUT | B_YIN | B_RUN, "add stop T3");
    push(B_GRC | B_ROUT | B_ADD | B_ZIN | B_RUN, "add stop T4");
    push(B_ZLOW | B_GRA | B_RIN | B_RUN, "add stop T5");
    push(ZERO, "halt after stop 1");
    push(ZERO, "halt after stop 2");
    cycles(4); Stop = 1'b1;
    cycles(2); Stop = 1'b0;
    cycles(2);
    reset_pulse("clear from stop halt");

    // Clear_n during ld T6: outputs drop that cycle, then a full ld restarts from T0.
    IR = 32'h00000000;
    push_fetch("ld abort");
    push(B_GRB | B_BAOUT | B_YIN | B_RUN, "ld abort T3");
    push(B_COUT | B_ADD | B_ZIN | B_RUN, "ld abort T4");
    push(B_ZLOW | B_MARIN | B_RUN, "ld abort T5");
    cycles(6);
    reset_pulse("clear in ld T6");
    add(B_GRB | B_BAOUT | B_YIN); add(B_COUT | B_ADD | B_ZIN); add(B_ZLOW | B_MARIN);
    add(B_READ | B_MDRIN); add(B_MDROUT | B_GRA | B_RIN);
    instr(32'h00000000, 1'b0, "ld after abort");

    IR = 32'hF8000000;
    push_fetch("illegal");
    push(B_RUN, "illegal T3");
    push(ZERO, "illegal halt 1");
    push(ZERO, "illegal halt 2");
    cycles(6);
    reset_pulse("clear from illegal halt");

    IR = 32'hD8000000;
    push_fetch("halt op");
    push(B_RUN, "halt op T3");
    push(ZERO, "halt op halt 1");
    push(ZERO, "halt op halt 2");
    cycles(6);
    reset_pulse("clear from halt op");

    add(ZERO);
    instr(32'hD0000000, 1'b0, "nop");

`ifdef MEM_WAIT_EN
    IR = 32'h10000000;
    push_fetch("st wait");
    push(B_GRB | B_BAOUT | B_YIN | B_RUN, "st wait T3");
    push(B_COUT | B_ADD | B_ZIN | B_RUN, "st wait T4");
    push(B_ZLOW | B_MARIN | B_RUN, "st wait T5");
    push(B_GRA | B_ROUT | B_MDRIN | B_RUN, "st wait T6");
    for (int i = 0; i < 4; i++) push(B_WRITE | B_RUN, $sformatf("st wait T7 cycle %0d", i));
    cycles(7); Mem_ready = 1'b0;
    cycles(3); Mem_ready = 1'b1;
    cycles(1);

    IR = 32'hD0000000;
    Mem_ready = 1'b0;
    push(F0, "timeout T0");
    for (int i = 0; i < 15; i++) push(F1, $sformatf("timeout T1 cycle %0d", i));
    push(B_ERR, "timeout halt 1");
    push(B_ERR, "timeout halt 2");
    cycles(18);
    Mem_ready = 1'b1;
    reset_pulse("clear after timeout");
    add(ZERO);
    instr(32'hD0000000, 1'b0, "nop after timeout");
`endif

    cycles(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
